tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive-side counterpart of the mux datapath.
- Accepts a serial time-division-multiplexed bit stream with a frame-sync marker, deserializes each slot and routes it to one of NUM_CH registered channel outputs.
- Sits between a serial link front-end and per-channel consumers.
- Tracks frame lock and flags framing errors.

Parameters:
- NUM_CH, 4: number of TDM channels (slots per frame), ≥2.
- SLOT_W, 8: data bits per slot, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  qualifies ser_in/frame_sync this cycle; all inputs ignored when 0.
- ser_in  in  1  serial data, MSB first within each slot.
- frame_sync  in  1  high with bit_en on bit 0 of slot 0.
- ch_data  out  NUM_CH*SLOT_W  registered channel words; channel k at bits [k*SLOT_W +: SLOT_W].
- ch_valid  out  NUM_CH  one-cycle pulse; bit k set when ch_data slice k updates.
- frame_done  out  1  one-cycle pulse with ch_valid of the last channel.
- frame_err  out  1  one-cycle framing-error pulse.
- locked  out  1  high while in RUN state.

Behaviour:
- Reset (async, rst_n=0):
  - ch_data=0, ch_valid=0, frame_done=0, frame_err=0, locked=0.
  - State HUNT, counters cleared.
- States: HUNT, RUN.
  - HUNT: discard bits until a qualified frame_sync. That bit is slot 0, bit 0: shift it in, set bit_cnt=1, slot_cnt=0, go RUN. locked rises the cycle after.
  - RUN: each qualified bit shifts into the slot shift register. bit_cnt counts 0..SLOT_W-1; slot_cnt counts 0..NUM_CH-1, wraps to 0 after the last slot.
- Slot completion: on the qualified bit with bit_cnt=SLOT_W-1, the next cycle:
  - ch_data[slot_cnt] takes the full word, ch_valid[slot_cnt]=1.
  - Latency: 1 clk after the last bit. All other ch_data slices hold.
- frame_done pulses in the same cycle as ch_valid[NUM_CH-1].
- Expected sync: at slot 0, bit 0 of every frame after the first.
  - Qualified bit at that position with frame_sync=0: frame_err pulse, bit discarded, state HUNT, locked=0 next cycle.
- Early sync: frame_sync at any other position in RUN:
  - frame_err pulse.
  - Partial slot discarded; no ch_valid for it.
  - Treated as a fresh slot 0, bit 0 (resync); stay RUN, locked stays 1.
- bit_en=0: no state change; gaps of any length allowed mid-slot.
- ch_valid, frame_done and frame_err are zero in all cycles not listed above.
- Reset mid-frame: immediate clear; a partial slot is never emitted.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Each slot carries SLOT_W data bits plus one trailing even-parity bit (slot length SLOT_W+1).
  - Adds output parity_err (1 bit, reset 0).
  - On mismatch: parity_err pulses in the cycle ch_valid would have, ch_valid for that slot stays 0, ch_data slice holds.
  - frame_done still pulses after the last slot.
- Undefined: slot length SLOT_W, no parity_err port.

Decomposition:
- Package tdm_demux_pkg:
  - state enum (HUNT, RUN).
  - Width helper constants: BIT_CNT_W = $clog2(SLOT_W+1), SLOT_CNT_W = $clog2(NUM_CH).
- Sub-module tdm_slot_deser: shift register plus bit counter, emitting word and word_done. The top holds the FSM, slot counter and channel registers.

Test Plan (NUM_CH=4, SLOT_W=8, parity off unless stated):
- Reset then one frame, bit_en=1 continuous, sync on first bit, slots A5,3C,FF,00 → 4 ch_valid pulses (one per channel, 8 clk apart), ch_data=00_FF_3C_A5, frame_done with ch_valid[3], locked=1.
- Same frame with bit_en toggling 1/0 each cycle → identical ch_data, pulses 16 clk apart, no frame_err.
- Second frame without frame_sync on its first bit → frame_err pulse, locked=0, ch_data holds; next sync relocks.
- frame_sync at slot 1, bit 3 → frame_err pulse, no ch_valid[1], subsequent 8 bits land in ch_data[0].
- rst_n low at slot 2, bit 4, release, send full frame → all outputs 0 during reset, no spurious ch_valid, clean frame decoded.
- TDM_DEMUX_PARITY_EN: slot 2 = 0x81 with parity bit 1 → parity_err pulse, ch_valid[2]=0, ch_data[2] unchanged; correct parity → normal update.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and width helpers for the TDM demultiplexer.
// Optional build macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity bit to each slot.
package tdm_demux_pkg;

  typedef enum logic [0:0] {
    StHunt,
    StRun
  } state_e;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Bit counter must hold 0..SLOT_W (covers the extra parity position).
  function automatic int unsigned bit_cnt_w(input int unsigned slot_w);
    return $clog2(slot_w + 1);
  endfunction

  function automatic int unsigned slot_cnt_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_deser.sv
// Slot deserializer: MSB-first shift register plus in-slot bit counter.
// word presents the completed slot combinationally on the cycle of its last bit.
module tdm_slot_deser #(
  parameter int unsigned SLOT_LEN = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic                restart,
  input  logic                din,
  output logic [SLOT_LEN-1:0] word,
  output logic [CNT_W-1:0]    bit_cnt,
  output logic                word_done
);

  localparam int unsigned SregW = SLOT_LEN - 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(SLOT_LEN - 1);

  logic [SregW-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q;

  // Assemble the word including the bit being shifted in this cycle.
  always_comb begin
    word      = {sreg_q, din};
    bit_cnt   = cnt_q;
    word_done = shift_en && !restart && (cnt_q == LastBit);
  end

  // Shift register and bit counter; restart makes this bit bit 0 of a new slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      if (restart) begin
        sreg_q <= SregW'(din);
        cnt_q  <= CNT_W'(1);
      end else begin
        sreg_q <= word[SregW-1:0];
        cnt_q  <= (cnt_q == LastBit) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer top: frame-lock FSM, slot counter and registered channel outputs.
// Optional build macro: TDM_DEMUX_PARITY_EN (adds parity_err port, slot length SLOT_W+1).
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_en,
  input  logic                     ser_in,
  input  logic                     frame_sync,
  output logic [NUM_CH*SLOT_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     locked
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned SLOT_LEN   = SLOT_W + ParityBits;
  localparam int unsigned BIT_CNT_W  = bit_cnt_w(SLOT_W);
  localparam int unsigned SLOT_CNT_W = slot_cnt_w(NUM_CH);
  localparam logic [SLOT_CNT_W-1:0] LastSlot = SLOT_CNT_W'(NUM_CH - 1);

  state_e                  state_q, state_d;
  logic [SLOT_CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic                    shift_en, restart, frame_err_d;
  logic [SLOT_LEN-1:0]     word;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    word_done;
  logic [SLOT_W-1:0]       data_word;
  logic                    parity_ok;

  logic [NUM_CH*SLOT_W-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]        ch_valid_q, ch_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_err_q;
  logic                     parity_err_q, parity_err_d;

  tdm_slot_deser #(
    .SLOT_LEN (SLOT_LEN),
    .CNT_W    (BIT_CNT_W)
  ) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .restart   (restart),
    .din       (ser_in),
    .word      (word),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  assign data_word = word[SLOT_LEN-1 -: SLOT_W];
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_ok = ~^word;
`else
  assign parity_ok = 1'b1;
`endif

  // Frame-lock FSM: next state, slot counter and deserializer control.
  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    shift_en    = 1'b0;
    restart     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (bit_en && frame_sync) begin
          shift_en   = 1'b1;
          restart    = 1'b1;
          slot_cnt_d = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (bit_en) begin
          if ((slot_cnt_q == '0) && (bit_cnt == '0)) begin
            // Frame boundary: sync is mandatory here, otherwise lock is lost.
            if (frame_sync) begin
              shift_en = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StHunt;
            end
          end else if (frame_sync) begin
            // Early sync: drop the partial slot and resync on this bit.
            frame_err_d = 1'b1;
            shift_en    = 1'b1;
            restart     = 1'b1;
            slot_cnt_d  = '0;
          end else begin
            shift_en = 1'b1;
            if (word_done) begin
              slot_cnt_d = (slot_cnt_q == LastSlot) ? '0 : slot_cnt_q + SLOT_CNT_W'(1);
            end
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // Channel update on slot completion; parity failure suppresses the update.
  always_comb begin
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = word_done && (slot_cnt_q == LastSlot);
    parity_err_d = word_done && !parity_ok;
    if (word_done && parity_ok) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (slot_cnt_q == SLOT_CNT_W'(k)) begin
          ch_valid_d[k]                = 1'b1;
          ch_data_d[k*SLOT_W +: SLOT_W] = data_word;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      slot_cnt_q   <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign locked     = (state_q == StRun);
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NUM_CH=4, SLOT_W=8).
// Build with TDM_DEMUX_PARITY_EN to also cover the parity variant.
module tb_tdm_demux;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_LEN = SLOT_W + 1;
`else
  localparam int SLOT_LEN = SLOT_W;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_en = 1'b0;
  logic        ser_in = 1'b0;
  logic        frame_sync = 1'b0;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done, frame_err, locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic        parity_err;
  logic        par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  tdm_demux #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .ser_in     (ser_in),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .locked     (locked)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt[NUM_CH];
  int vcyc[NUM_CH];
  int fdcnt, fecnt, pecnt, fd_mis, unlock_cnt;

  task automatic clear_counts();
    for (int k = 0; k < NUM_CH; k++) begin
      vcnt[k] = 0;
      vcyc[k] = 0;
    end
    fdcnt = 0; fecnt = 0; pecnt = 0; fd_mis = 0; unlock_cnt = 0;
  endtask

  // Drive one cycle from a falling edge, observe just after the rising edge.
  task automatic tick(input logic en, input logic din, input logic sync);
    bit_en = en; ser_in = din; frame_sync = sync;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid[k]) begin
        vcnt[k]++;
        vcyc[k] = cyc;
      end
    end
    if (frame_done) fdcnt++;
    if (frame_done !== ch_valid[NUM_CH-1]) fd_mis++;
    if (frame_err) fecnt++;
    if (!locked) unlock_cnt++;
`ifdef TDM_DEMUX_PARITY_EN
    if (parity_err) pecnt++;
`endif
    @(negedge clk);
  endtask

  task automatic gap_tick();
    tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [7:0] w, input logic sync, input logic gap);
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, w[i], sync && (i == 7));
      if (gap) gap_tick();
    end
`ifdef TDM_DEMUX_PARITY_EN
    tick(1'b1, (^w) ^ par_flip, 1'b0);
    if (gap) gap_tick();
`endif
  endtask

  task automatic send_frame(input logic [31:0] f, input logic gap);
    send_word(f[7:0], 1'b1, gap);
    send_word(f[15:8], 1'b0, gap);
    send_word(f[23:16], 1'b0, gap);
    send_word(f[31:24], 1'b0, gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ch_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", ch_data); end
    n_checks++; if (ch_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ch_valid); end
    n_checks++; if ({frame_done, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
`ifdef TDM_DEMUX_PARITY_EN
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int start;
    clear_counts();
    start = cyc;
    send_frame(32'h00FF3CA5, 1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      n_checks++; if (vcnt[k] !== 1) begin n_fail++; $display("FAIL frame_valid_cnt[%0d]: got %0d expected 1", k, vcnt[k]); end
    end
    n_checks++; if (ch_data !== 32'h00FF3CA5) begin n_fail++; $display("FAIL frame_data: got %h expected 00ff3ca5", ch_data); end
    n_checks++; if (vcyc[0] - start !== SLOT_LEN) begin n_fail++; $display("FAIL frame_latency: got %0d expected %0d", vcyc[0] - start, SLOT_LEN); end
    for (int k = 0; k < NUM_CH - 1; k++) begin
      n_checks++; if (vcyc[k+1] - vcyc[k] !== SLOT_LEN) begin n_fail++; $display("FAIL frame_spacing[%0d]: got %0d expected %0d", k, vcyc[k+1] - vcyc[k], SLOT_LEN); end
    end
    n_checks++; if (fdcnt !== 1 || fd_mis !== 0) begin n_fail++; $display("FAIL frame_done: got cnt %0d mis %0d expected 1 0", fdcnt, fd_mis); end
    n_checks++; if (fecnt !== 0) begin n_fail++; $display("FAIL frame_err_none: got %0d expected 0", fecnt); end
    n_checks++; if (unlock_cnt !== 0 || locked !== 1'b1) begin n_fail++; $display("FAIL frame_locked: got unlock %0d locked %b expected 0 1", unlock_cnt, locked); end
  endtask

  task automatic test_bit_en_gaps();
    int start;
    clear_counts();
    start = cyc;
    send_frame(32'h00FF3CA5, 1'b1);
    n_checks++; if (ch_data !== 32'h00FF3CA5) begin n_fail++; $display("FAIL gap_data: got %h expected 00ff3ca5", ch_data); end
    n_checks++; if (vcyc[0] - start !== 2 * SLOT_LEN - 1) begin n_fail++; $display("FAIL gap_latency: got %0d expected %0d", vcyc[0] - start, 2 * SLOT_LEN - 1); end
    for (int k = 0; k < NUM_CH - 1; k++) begin
      n_checks++; if (vcnt[k] !== 1 || vcyc[k+1] - vcyc[k] !== 2 * SLOT_LEN) begin n_fail++; $display("FAIL gap_spacing[%0d]: got cnt %0d gap %0d expected 1 %0d", k, vcnt[k], vcyc[k+1] - vcyc[k], 2 * SLOT_LEN); end
    end
    n_checks++; if (fecnt !== 0 || fdcnt !== 1 || fd_mis !== 0) begin n_fail++; $display("FAIL gap_pulses: got err %0d done %0d mis %0d expected 0 1 0", fecnt, fdcnt, fd_mis); end
  endtask

  task automatic test_missing_sync();
    clear_counts();
    send_word(8'h12, 1'b0, 1'b0);
    n_checks++; if (fecnt !== 1) begin n_fail++; $display("FAIL miss_err: got %0d expected 1", fecnt); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL miss_locked: got %b expected 0", locked); end
    n_checks++; if (vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] !== 0 || fdcnt !== 0) begin n_fail++; $display("FAIL miss_no_valid: got %0d/%0d expected 0/0", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], fdcnt); end
    n_checks++; if (ch_data !== 32'h00FF3CA5) begin n_fail++; $display("FAIL miss_hold: got %h expected 00ff3ca5", ch_data); end
    send_frame(32'h44332211, 1'b0);
    n_checks++; if (ch_data !== 32'h44332211) begin n_fail++; $display("FAIL relock_data: got %h expected 44332211", ch_data); end
    n_checks++; if (locked !== 1'b1 || fecnt !== 1) begin n_fail++; $display("FAIL relock_state: got locked %b err %0d expected 1 1", locked, fecnt); end
    n_checks++; if (vcnt[3] !== 1 || fdcnt !== 1) begin n_fail++; $display("FAIL relock_done: got v3 %0d done %0d expected 1 1", vcnt[3], fdcnt); end
  endtask

  task automatic test_early_sync();
    clear_counts();
    send_word(8'h55, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    send_word(8'h9C, 1'b1, 1'b0);
    n_checks++; if (ch_data !== 32'h4433229C) begin n_fail++; $display("FAIL early_data: got %h expected 4433229c", ch_data); end
    n_checks++; if (vcnt[0] !== 2 || vcnt[1] !== 0) begin n_fail++; $display("FAIL early_valid: got v0 %0d v1 %0d expected 2 0", vcnt[0], vcnt[1]); end
    n_checks++; if (fecnt !== 1) begin n_fail++; $display("FAIL early_err: got %0d expected 1", fecnt); end
    send_word(8'h77, 1'b0, 1'b0);
    send_word(8'h66, 1'b0, 1'b0);
    send_word(8'h88, 1'b0, 1'b0);
    n_checks++; if (ch_data !== 32'h8866779C) begin n_fail++; $display("FAIL early_frame: got %h expected 8866779c", ch_data); end
    n_checks++; if (unlock_cnt !== 0 || fdcnt !== 1 || fecnt !== 1) begin n_fail++; $display("FAIL early_lock: got unlock %0d done %0d err %0d expected 0 1 1", unlock_cnt, fdcnt, fecnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h02, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ch_data !== 32'h0 || ch_valid !== 4'h0) begin n_fail++; $display("FAIL rstmid_clear: got %h %b expected 0 0", ch_data, ch_valid); end
    n_checks++; if ({locked, frame_done, frame_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 000", {locked, frame_done, frame_err}); end
    clear_counts();
    repeat (4) tick(1'b1, 1'b1, 1'b0);
    n_checks++; if (vcnt[2] + vcnt[3] + fdcnt + fecnt !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d expected 0", vcnt[2] + vcnt[3] + fdcnt + fecnt); end
    rst_n = 1'b1;
    clear_counts();
    send_frame(32'hEFBEADDE, 1'b0);
    n_checks++; if (ch_data !== 32'hEFBEADDE) begin n_fail++; $display("FAIL rstmid_frame: got %h expected efbeadde", ch_data); end
    n_checks++; if (vcnt[0] !== 1 || vcnt[2] !== 1 || fdcnt !== 1 || fecnt !== 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d %0d %0d %0d expected 1 1 1 0", vcnt[0], vcnt[2], fdcnt, fecnt); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    clear_counts();
    send_word(8'h10, 1'b1, 1'b0);
    send_word(8'h20, 1'b0, 1'b0);
    par_flip = 1'b1;
    send_word(8'h81, 1'b0, 1'b0);
    par_flip = 1'b0;
    send_word(8'h30, 1'b0, 1'b0);
    n_checks++; if (pecnt !== 1 || vcnt[2] !== 0) begin n_fail++; $display("FAIL parity_bad: got perr %0d v2 %0d expected 1 0", pecnt, vcnt[2]); end
    n_checks++; if (ch_data !== 32'h30BE2010) begin n_fail++; $display("FAIL parity_hold: got %h expected 30be2010", ch_data); end
    n_checks++; if (fdcnt !== 1) begin n_fail++; $display("FAIL parity_done: got %0d expected 1", fdcnt); end
    clear_counts();
    send_frame(32'h30812010, 1'b0);
    n_checks++; if (ch_data !== 32'h30812010 || vcnt[2] !== 1 || pecnt !== 0) begin n_fail++; $display("FAIL parity_good: got %h v2 %0d perr %0d expected 30812010 1 0", ch_data, vcnt[2], pecnt); end
  endtask
`endif

  initial begin
    clear_counts();
    @(negedge clk);
    test_reset();
    test_frame();
    test_bit_en_gaps();
    test_missing_sync();
    test_early_sync();
    test_reset_mid_frame();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish within 2 ms");
    $fatal(1, "timeout");
  end

endmodule
